// File: rtl/mouse_pkg.sv
// Shared constants and types for the PS/2 mouse tracker: status-byte layout,
// receiver state encoding, default screen limits and delta/position types.
package mouse_pkg;

  localparam int STAT_L    = 0;
  localparam int STAT_R    = 1;
  localparam int STAT_M    = 2;
  localparam int STAT_ONE  = 3;
  localparam int STAT_XS   = 4;
  localparam int STAT_YS   = 5;
  localparam int STAT_XOVF = 6;
  localparam int STAT_YOVF = 7;

  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_e;

  typedef logic signed [8:0]  delta_t;
  typedef logic signed [10:0] pos_t;

  // Status byte fields still needed once bytes 1 and 2 arrive.
  typedef struct packed {
    logic       y_ovf;
    logic       x_ovf;
    logic       y_sign;
    logic       x_sign;
    logic [2:0] btn;
  } status_t;

endpackage

// File: rtl/ps2_rx_byte.sv
// PS/2 device-to-host byte receiver: pin synchronizers, falling-edge detect,
// 11-bit frame FSM and mid-frame timeout. Parity enforced with PS2_PARITY_CHECK_EN.
module ps2_rx_byte
  import mouse_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_strobe,
  output logic       err
);

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_CHECK = 1'b1;
`else
  localparam bit PAR_CHECK = 1'b0;
`endif

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic             clk_meta_q, clk_sync_q, clk_prev_q;
  logic             data_meta_q, data_sync_q;
  rx_state_e        state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             strobe_q, strobe_d;
  logic             err_q, err_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       byte_q, byte_d;
  logic             par_ok_q, par_ok_d;
  logic             fall, timeout;

  // Idle bus is high, so the synchronizers come out of reset at 1 to avoid a false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      state_q     <= RX_IDLE;
      bit_cnt_q   <= '0;
      to_cnt_q    <= '0;
      strobe_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      to_cnt_q    <= to_cnt_d;
      strobe_q    <= strobe_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q  <= shift_d;
    byte_q   <= byte_d;
    par_ok_q <= par_ok_d;
  end

  assign fall    = clk_prev_q & ~clk_sync_q;
  assign timeout = (state_q != RX_IDLE) && !fall &&
                   (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    par_ok_d  = par_ok_q;
    strobe_d  = 1'b0;
    err_d     = 1'b0;
    to_cnt_d  = (fall || state_q == RX_IDLE) ? '0 : to_cnt_q + CNT_W'(1);

    if (fall) begin
      case (state_q)
        RX_IDLE: begin
          if (!data_sync_q) begin
            state_d   = RX_DATA;
            bit_cnt_d = '0;
          end
        end
        RX_DATA: begin
          shift_d   = {data_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
        end
        RX_PARITY: begin
          par_ok_d = ^{shift_q, data_sync_q};
          state_d  = RX_STOP;
        end
        default: begin
          state_d = RX_IDLE;
          if (!data_sync_q || (PAR_CHECK && !par_ok_q)) begin
            err_d = 1'b1;
          end else begin
            strobe_d = 1'b1;
            byte_d   = shift_q;
          end
        end
      endcase
    end else if (timeout) begin
      state_d = RX_IDLE;
      err_d   = 1'b1;
    end
  end

  assign rx_byte     = byte_q;
  assign byte_strobe = strobe_q;
  assign err         = err_q;

endmodule

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse packet decoder and clamped absolute cursor tracker for the VGA path.
// Build option PS2_PARITY_CHECK_EN makes the receiver reject bad-parity bytes.
module ps2_mouse_tracker
  import mouse_pkg::*;
#(
  parameter int SCREEN_W       = DEF_SCREEN_W,
  parameter int SCREEN_H       = DEF_SCREEN_H,
  parameter int X_INIT         = 320,
  parameter int Y_INIT         = 240,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [9:0] mouse_x,
  output logic [8:0] mouse_y,
  output logic       btn_left,
  output logic       btn_right,
  output logic       btn_middle,
  output logic       pos_valid,
  output logic       frame_err
);

  localparam pos_t X_MAX = pos_t'(SCREEN_W - 1);
  localparam pos_t Y_MAX = pos_t'(SCREEN_H - 1);

  logic [7:0] rx_byte;
  logic       rx_strobe, rx_err;

  ps2_rx_byte #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_byte    (rx_byte),
    .byte_strobe(rx_strobe),
    .err        (rx_err)
  );

  function automatic pos_t delta(input logic sign, input logic ovf, input logic [7:0] low);
    delta_t d;
    d = {sign, low};
    if (ovf) d = '0;
    return pos_t'(d);
  endfunction

  function automatic pos_t clamp(input pos_t v, input pos_t hi);
    if (v < pos_t'(0)) return '0;
    if (v > hi)        return hi;
    return v;
  endfunction

  logic [1:0] idx_q, idx_d;
  status_t    status_q, status_d;
  logic [7:0] dx_byte_q, dx_byte_d;
  logic [9:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  logic [2:0] btn_q, btn_d;
  logic       pv_q, pv_d;
  logic       ferr_q, ferr_d;
  pos_t       dx, dy, x_new, y_new;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= 2'd0;
      x_q    <= 10'(X_INIT);
      y_q    <= 9'(Y_INIT);
      btn_q  <= 3'b000;
      pv_q   <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      x_q    <= x_d;
      y_q    <= y_d;
      btn_q  <= btn_d;
      pv_q   <= pv_d;
      ferr_q <= ferr_d;
    end
  end

  always_ff @(posedge clk) begin
    status_q  <= status_d;
    dx_byte_q <= dx_byte_d;
  end

  // PS/2 dy is positive upward while screen y grows downward, hence the subtraction.
  assign dx    = delta(status_q.x_sign, status_q.x_ovf, dx_byte_q);
  assign dy    = delta(status_q.y_sign, status_q.y_ovf, rx_byte);
  assign x_new = clamp(pos_t'({1'b0, x_q}) + dx, X_MAX);
  assign y_new = clamp(pos_t'({2'b00, y_q}) - dy, Y_MAX);

  always_comb begin
    idx_d     = idx_q;
    status_d  = status_q;
    dx_byte_d = dx_byte_q;
    x_d       = x_q;
    y_d       = y_q;
    btn_d     = btn_q;
    pv_d      = 1'b0;
    ferr_d    = 1'b0;

    if (rx_err) begin
      idx_d  = 2'd0;
      ferr_d = 1'b1;
    end else if (rx_strobe) begin
      case (idx_q)
        2'd0: begin
          // Bit 3 is always set in a real status byte; anything else means we are misaligned.
          if (rx_byte[STAT_ONE]) begin
            status_d.btn    = {rx_byte[STAT_M], rx_byte[STAT_R], rx_byte[STAT_L]};
            status_d.x_sign = rx_byte[STAT_XS];
            status_d.y_sign = rx_byte[STAT_YS];
            status_d.x_ovf  = rx_byte[STAT_XOVF];
            status_d.y_ovf  = rx_byte[STAT_YOVF];
            idx_d           = 2'd1;
          end else begin
            ferr_d = 1'b1;
          end
        end
        2'd1: begin
          dx_byte_d = rx_byte;
          idx_d     = 2'd2;
        end
        default: begin
          x_d   = 10'(x_new);
          y_d   = 9'(y_new);
          btn_d = status_q.btn;
          pv_d  = 1'b1;
          idx_d = 2'd0;
        end
      endcase
    end
  end

  assign mouse_x    = x_q;
  assign mouse_y    = y_q;
  assign btn_left   = btn_q[0];
  assign btn_right  = btn_q[1];
  assign btn_middle = btn_q[2];
  assign pos_valid  = pv_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Directed bench for ps2_mouse_tracker: PS/2 frames are bit-banged, a packet-level
// model predicts cursor/button state and pulse cycles, checked every cycle.
module tb_ps2_mouse_tracker;

  localparam int T   = 500;
  localparam int H   = 8;
  localparam int GAP = 20;
  localparam int SW  = 640;
  localparam int SH  = 480;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [9:0] mouse_x;
  logic [8:0] mouse_y;
  logic       btn_left, btn_right, btn_middle, pos_valid, frame_err;

  ps2_mouse_tracker #(
    .SCREEN_W(SW), .SCREEN_H(SH), .X_INIT(320), .Y_INIT(240), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .mouse_x(mouse_x), .mouse_y(mouse_y),
    .btn_left(btn_left), .btn_right(btn_right), .btn_middle(btn_middle),
    .pos_valid(pos_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Model state: m_* tracks packet assembly, v_* is what the outputs must show now,
  // p_* is the update that becomes visible at exp_cyc.
  int m_x, m_y, m_btn, m_idx, m_stat, m_b1;
  int v_x, v_y, v_btn;
  int p_x, p_y, p_btn;
  int exp_cyc = -100;
  int exp_kind = 0;
  int last_fall_cyc = 0;
  bit to_active = 1'b0;
  int to_lo = 0, to_hi = 0, to_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_init();
    m_x = 320; m_y = 240; m_btn = 0; m_idx = 0; m_stat = 0; m_b1 = 0;
    v_x = 320; v_y = 240; v_btn = 0;
    exp_kind = 0; exp_cyc = -100; to_active = 1'b0;
  endtask

  task automatic model_byte(input int b, input bit bad_par, input bit bad_stop, input int at_cyc);
    int kind, dx, dy;
    bit par_bad;
`ifdef PS2_PARITY_CHECK_EN
    par_bad = bad_par;
`else
    par_bad = 1'b0;
`endif
    kind = 0;
    if (bad_stop || par_bad) begin
      m_idx = 0; kind = 2;
    end else if (m_idx == 0) begin
      if ((b & 8) != 0) begin m_stat = b; m_idx = 1; end
      else kind = 2;
    end else if (m_idx == 1) begin
      m_b1 = b; m_idx = 2;
    end else begin
      dx = ((m_stat & 16) != 0) ? m_b1 - 256 : m_b1;
      dy = ((m_stat & 32) != 0) ? b - 256 : b;
      if ((m_stat & 64) != 0)  dx = 0;
      if ((m_stat & 128) != 0) dy = 0;
      m_x = m_x + dx;
      m_y = m_y - dy;
      if (m_x < 0) m_x = 0;
      if (m_x > SW - 1) m_x = SW - 1;
      if (m_y < 0) m_y = 0;
      if (m_y > SH - 1) m_y = SH - 1;
      m_btn = m_stat & 7;
      m_idx = 0;
      kind  = 1;
      p_x = m_x; p_y = m_y; p_btn = m_btn;
    end
    exp_kind = kind;
    exp_cyc  = at_cyc + 4;
  endtask

  // Pins driven on the falling clk edge; the stop-bit fall seen here lands on outputs 4 edges later.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
    logic [10:0] fr;
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = fr[i];
      repeat (H) @(negedge clk);
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      if (i == 10) model_byte(int'(b), bad_par, bad_stop, cyc);
      repeat (H) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_frame(b0, 1'b0, 1'b0, 11);
    send_frame(b1, 1'b0, 1'b0, 11);
    send_frame(b2, 1'b0, 1'b0, 11);
  endtask

  always @(negedge clk) begin
    logic pv_exp, fe_exp, in_to;
    pv_exp = (cyc == exp_cyc) && (exp_kind == 1);
    fe_exp = (cyc == exp_cyc) && (exp_kind == 2);
    in_to  = to_active && (cyc >= to_lo) && (cyc <= to_hi);
    if (pv_exp) begin
      v_x = p_x; v_y = p_y; v_btn = p_btn;
    end
    chk("pos_valid", 32'(pos_valid), 32'(pv_exp));
    if (in_to) begin
      if (frame_err === 1'b1) to_seen++;
    end else begin
      chk("frame_err", 32'(frame_err), 32'(fe_exp));
    end
    chk("mouse_x", 32'(mouse_x), v_x);
    chk("mouse_y", 32'(mouse_y), v_y);
    chk("buttons", 32'({btn_middle, btn_right, btn_left}), v_btn);
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_init();
    repeat (3) @(negedge clk);
    chk("rst_x", 32'(mouse_x), 320);
    chk("rst_y", 32'(mouse_y), 240);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (1000) @(negedge clk);
    chk("idle_x", 32'(mouse_x), 320);
    chk("idle_y", 32'(mouse_y), 240);

    send_packet(8'h08, 8'h0A, 8'h05);
    chk("p1_x", 32'(mouse_x), 330);
    chk("p1_y", 32'(mouse_y), 235);
    send_packet(8'h19, 8'hF6, 8'h00);
    chk("p2_x", 32'(mouse_x), 320);
    chk("p2_left", 32'(btn_left), 1);
    send_packet(8'h08, 8'h00, 8'h00);
    chk("p3_left", 32'(btn_left), 0);

    send_frame(8'h08, 1'b0, 1'b0, 11);
    send_frame(8'h05, 1'b1, 1'b0, 11);
`ifndef PS2_PARITY_CHECK_EN
    send_frame(8'h00, 1'b0, 1'b0, 11);
`endif
    send_packet(8'h08, 8'h01, 8'h01);
`ifdef PS2_PARITY_CHECK_EN
    chk("par_x", 32'(mouse_x), 321);
`else
    chk("par_x", 32'(mouse_x), 326);
`endif
    chk("par_y", 32'(mouse_y), 234);

    send_frame(8'h08, 1'b0, 1'b0, 11);
    send_frame(8'h0A, 1'b0, 1'b1, 11);
    send_packet(8'h08, 8'h01, 8'h00);
`ifdef PS2_PARITY_CHECK_EN
    chk("stop_x", 32'(mouse_x), 322);
`else
    chk("stop_x", 32'(mouse_x), 327);
`endif

    repeat (5) send_packet(8'h08, 8'h7F, 8'h00);
    chk("xmax", 32'(mouse_x), 639);
    repeat (3) send_packet(8'h28, 8'h81, 8'h00);
    chk("ymax", 32'(mouse_y), 479);
    send_packet(8'h58, 8'hFF, 8'h00);
    chk("xovf_x", 32'(mouse_x), 639);
    repeat (5) send_packet(8'h18, 8'h80, 8'h00);
    chk("xmin", 32'(mouse_x), 0);
    repeat (4) send_packet(8'h08, 8'h00, 8'h7F);
    chk("ymin", 32'(mouse_y), 0);

    send_frame(8'h08, 1'b0, 1'b0, 11);
    send_frame(8'h05, 1'b0, 1'b0, 5);
    m_idx = 0;
    to_seen = 0;
    to_lo = last_fall_cyc + T;
    to_hi = last_fall_cyc + T + 10;
    to_active = 1'b1;
    repeat (T + 30) @(negedge clk);
    to_active = 1'b0;
    chk("timeout_err_cycles", to_seen, 1);
    send_packet(8'h08, 8'h02, 8'h00);
    chk("timeout_x", 32'(mouse_x), 2);

    send_frame(8'h00, 1'b0, 1'b0, 11);
    send_packet(8'h08, 8'h02, 8'h00);
    chk("sync_x", 32'(mouse_x), 4);

    send_frame(8'h08, 1'b0, 1'b0, 11);
    send_frame(8'h05, 1'b0, 1'b0, 11);
    send_frame(8'h00, 1'b0, 1'b0, 4);
    @(posedge clk); #2 rst_n = 1'b0;
    model_init();
    @(negedge clk);
    chk("midrst_x", 32'(mouse_x), 320);
    chk("midrst_y", 32'(mouse_y), 240);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_packet(8'h08, 8'h03, 8'h00);
    chk("postrst_x", 32'(mouse_x), 323);

    repeat (10) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
